// File: rtl/cpu6502_pkg.sv
// Shared definitions for the CPU run controller: run-state encoding and cycle-counter width.
package cpu6502_pkg;

    localparam int CYC_W = 32;

    typedef enum logic [2:0] {
        ST_HOLD = 3'd0,
        ST_HALT = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } run_state_t;

endpackage

// File: rtl/clk_prescaler.sv
// Tick generator: one-CLK tick every DIV enabled CLK cycles; R or a low en clears the count.
module clk_prescaler #(
    parameter int DIV = 1
) (
    input  logic CLK,
    input  logic R,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (R || !en) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = en && (r_count == LAST);

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run controller: reset hold, run/halt/step/done sequencing, cpu clock and cycle counter.
// Optional breakpoint comparator is built only when BRKPT_EN is defined.
module cpu_run_ctrl
    import cpu6502_pkg::*;
#(
    parameter int          DIV       = 1,
    parameter int          RST_CYC   = 50,
    parameter int unsigned RUN_LIMIT = 0,
    parameter int          AUTO_RUN  = 1
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             run_req,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [15:0]      addr_bus,
    input  logic [15:0]      brk_addr,
    output logic             cpu_clk,
    output logic             cpu_res,
    output logic             running,
    output logic             halted,
    output logic             done,
    output logic             bp_hit,
    output logic [CYC_W-1:0] cyc_count
);

    localparam logic [31:0]      HOLD_TICKS = 32'(2 * RST_CYC);
    localparam logic [CYC_W-1:0] LIMIT      = CYC_W'(RUN_LIMIT);

    run_state_t       r_state;
    run_state_t       w_nextState;
    logic             w_tick;
    logic             w_fall;
    logic             w_bpHit;
    logic             w_holdDone;
    logic             w_stateChange;
    logic             w_prescEn;
    logic             w_prescClr;
    logic [CYC_W-1:0] w_cycNext;
    logic [CYC_W-1:0] r_cycCount;
    logic [31:0]      r_holdCnt;
    logic             r_cpuClk;
    logic             r_cpuRes;
    logic             r_running;
    logic             r_halted;
    logic             r_done;
    logic             r_bpHit;

    assign w_prescEn  = (r_state == ST_HOLD) || (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_prescClr = R || w_stateChange;

    clk_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .CLK (CLK),
        .R   (w_prescClr),
        .en  (w_prescEn),
        .tick(w_tick)
    );

    // A tick while cpu_clk is high is the falling edge that completes a cpu cycle.
    assign w_fall     = w_tick && r_cpuClk;
    assign w_cycNext  = r_cycCount + 1'b1;
    assign w_holdDone = w_tick && ((r_holdCnt + 32'd1) >= HOLD_TICKS);

`ifdef BRKPT_EN
    assign w_bpHit = (r_state == ST_RUN) && w_fall && (addr_bus == brk_addr);
`else
    logic w_unusedBrk;
    assign w_unusedBrk = ^{addr_bus, brk_addr};
    assign w_bpHit     = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_HOLD: begin
                if (w_holdDone) begin
                    w_nextState = (AUTO_RUN != 0) ? ST_RUN : ST_HALT;
                end
            end
            ST_HALT: begin
                if (halt_req) begin
                    w_nextState = ST_HALT;
                end else if (step_req) begin
                    w_nextState = ST_STEP;
                end else if (run_req) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fall) begin
                    if ((RUN_LIMIT != 0) && (w_cycNext == LIMIT)) begin
                        w_nextState = ST_DONE;
                    end else if (halt_req || w_bpHit) begin
                        w_nextState = ST_HALT;
                    end
                end
            end
            ST_STEP: begin
                if (w_fall) begin
                    w_nextState = ST_HALT;
                end
            end
            ST_DONE: begin
                w_nextState = ST_DONE;
            end
            default: begin
                w_nextState = ST_HOLD;
            end
        endcase
    end

    assign w_stateChange = (w_nextState != r_state);

    always_ff @(posedge CLK) begin
        if (R) begin
            r_state <= ST_HOLD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Outputs are derived from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK) begin
        if (R) begin
            r_holdCnt  <= '0;
            r_cpuClk   <= 1'b0;
            r_cpuRes   <= 1'b1;
            r_running  <= 1'b0;
            r_halted   <= 1'b0;
            r_done     <= 1'b0;
            r_bpHit    <= 1'b0;
            r_cycCount <= '0;
        end else begin
            if (r_state != ST_HOLD) begin
                r_holdCnt <= '0;
            end else if (w_tick) begin
                r_holdCnt <= r_holdCnt + 32'd1;
            end

            if ((w_nextState == ST_HALT) || (w_nextState == ST_DONE)) begin
                r_cpuClk <= 1'b0;
            end else if (w_tick) begin
                r_cpuClk <= ~r_cpuClk;
            end

            r_cpuRes  <= (w_nextState == ST_HOLD);
            r_running <= (w_nextState == ST_RUN) || (w_nextState == ST_STEP);
            r_halted  <= (w_nextState == ST_HALT);
            r_done    <= (w_nextState == ST_DONE);
            r_bpHit   <= w_bpHit;

            if (w_fall && ((r_state == ST_RUN) || (r_state == ST_STEP))) begin
                r_cycCount <= w_cycNext;
            end
        end
    end

    assign cpu_clk   = r_cpuClk;
    assign cpu_res   = r_cpuRes;
    assign running   = r_running;
    assign halted    = r_halted;
    assign done      = r_done;
    assign bp_hit    = r_bpHit;
    assign cyc_count = r_cycCount;

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameters SHALL be:
- DIV, default 1: CLK cycles per cpu_clk half-period tick, valid range 1..2^16.
- RST_CYC, default 50: cpu_clk periods with cpu_res high after reset.
- RUN_LIMIT, default 0: cpu cycles before DONE; 0 means unlimited.
- AUTO_RUN, default 1: after the reset hold, 1 enters RUN and 0 enters HALT.

REQ-002 Ports SHALL be:
- CLK  in  1  system clock; sole clock.
- R  in  1  synchronous active-high reset.
- run_req  in  1  level; leave HALT and run freely.
- step_req  in  1  single-cycle pulse; execute exactly one cpu cycle.
- halt_req  in  1  level; stop at the end of the current cpu cycle.
- addr_bus  in  16  CPU address bus.
- brk_addr  in  16  breakpoint address; used only when BRKPT_EN is defined.
- cpu_clk  out  1  CPU clock.
- cpu_res  out  1  CPU reset, active-high.
- running  out  1  high in RUN or STEP.
- halted  out  1  high in HALT.
- done  out  1  sticky; high once RUN_LIMIT is reached.
- bp_hit  out  1  one-CLK pulse on a breakpoint stop.
- cyc_count  out  32  count of completed cpu cycles.

Function
REQ-003 A prescaler SHALL assert tick for one CLK every DIV CLK cycles; its count SHALL run only in HOLD, RUN and STEP and SHALL clear on every state change.
REQ-004 The state machine SHALL have exactly the states HOLD, HALT, RUN, STEP and DONE.
REQ-005 cpu_clk SHALL toggle on tick in HOLD, RUN and STEP, and SHALL be held 0 in HALT and DONE.
REQ-006 A cpu cycle SHALL be one cpu_clk rise followed by one fall; the cycle completes on the fall.
REQ-007 HOLD SHALL drive cpu_res=1 and leave after RST_CYC complete cycles (2*RST_CYC ticks): to RUN if AUTO_RUN=1, else to HALT.
- cpu_res SHALL fall in the same CLK edge as the HOLD exit.
REQ-008 HALT transitions SHALL be evaluated each CLK with priority halt_req > step_req > run_req:
- halt_req high: stay in HALT.
- step_req high: go to STEP.
- run_req high: go to RUN.
REQ-009 RUN SHALL continue until a completing cpu_clk fall, where it exits as follows:
- to DONE if cycle-count == RUN_LIMIT and RUN_LIMIT != 0;
- else to HALT on halt_req or a breakpoint;
- else stay in RUN.
REQ-010 STEP SHALL complete exactly one cpu cycle and then go to HALT; halt_req SHALL NOT truncate a STEP, and step_req seen during STEP SHALL be ignored.
REQ-011 cyc_count SHALL increment by 1 at each completing fall in RUN or STEP only, wrapping 0xFFFFFFFF -> 0; cycles in HOLD SHALL NOT be counted.
REQ-012 RUN_LIMIT SHALL be compared against the post-increment cyc_count value.
REQ-013 Simultaneous limit and breakpoint SHALL go to DONE, with bp_hit still pulsing.
REQ-014 DONE SHALL be terminal until R: done=1, cpu_clk=0, and all requests ignored.
REQ-015 Output levels per state SHALL be:
- running=1 exactly in RUN and STEP;
- halted=1 exactly in HALT;
- all outputs SHALL be registered.
REQ-016 A step_req in RUN SHALL be ignored.

Reset
REQ-017 R=1 at a CLK edge SHALL force the following, from any state including mid-cycle:
- state=HOLD and prescaler=0;
- cpu_clk=0, cpu_res=1;
- running=0, halted=0, done=0, bp_hit=0, cyc_count=0.
REQ-018 A HOLD interrupted by R SHALL restart the full RST_CYC count.

Configuration
REQ-019 With BRKPT_EN defined, a breakpoint SHALL be addr_bus == brk_addr sampled at a completing fall in RUN, and it SHALL pulse bp_hit for one CLK.
REQ-020 Without BRKPT_EN:
- brk_addr SHALL be unused;
- bp_hit SHALL be constant 0;
- no comparator logic SHALL be generated.
REQ-021 A breakpoint SHALL NOT trigger in STEP, so the design can single-step off a breakpoint address.

Structure
REQ-022 State encodings (HOLD=0, HALT=1, RUN=2, STEP=3, DONE=4) and the cycle-count width of 32 SHALL live in the shared package cpu6502_pkg.
REQ-023 The tick generator SHALL be a sub-module, clk_prescaler (parameter DIV; ports CLK, R, en, tick); the state machine and counters SHALL stay in cpu_run_ctrl.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- DIV=1, RST_CYC=3, AUTO_RUN=1, R pulsed -> cpu_res high for exactly 6 CLK after R drops, then running=1 and cpu_clk toggling each CLK.
- RUN_LIMIT=10 -> done=1 after cyc_count=10, cpu_clk stuck 0, and run_req afterwards has no effect.
- AUTO_RUN=0, one step_req pulse -> exactly one cpu_clk rise and fall, cyc_count 0 -> 1, then halted=1; step_req and halt_req together keep HALT.
- halt_req asserted while cpu_clk=1 in RUN -> HALT entered on the next fall with no further rise; DIV=4 shows 4-CLK half-periods.
- BRKPT_EN defined, brk_addr=16'hFFFC, addr_bus=16'hFFFC at a fall -> bp_hit one CLK and HALT; same stimulus without the macro -> no stop.
- R asserted mid-RUN with cyc_count=5 -> next edge gives cpu_res=1, cyc_count=0, state HOLD.
